fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the LEGv8 core. It replaces the fixed PC register, the +4 adder and the shift/add branch-target path with one block. The block owns the PC, issues fetch requests to a variable-latency instruction memory through a valid/ready handshake, and buffers returned instructions in an in-order FIFO toward decode. Branch redirects compute the target internally, flush the buffer and discard stale in-flight responses.

---
 rtl/fetch_if.sv | 37 +++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: fetch-unit bus bundle covering the instruction-memory handshake,
// the decode-side buffer head, the branch redirect and the in-flight count.
interface fetch_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic                   imem_rsp_valid;
    logic [INSTR_WIDTH-1:0] imem_rsp_data;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_base;
    logic [ADDR_WIDTH-1:0]  redirect_offset;
    logic [CNT_W-1:0]       outstanding;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, outstanding,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_base, redirect_offset
    );

    // Memory / decode / branch-unit side
    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, outstanding,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_base, redirect_offset
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues credit-limited fetch requests, buffers
// in-order responses for decode and handles taken-branch redirects by
// flushing the buffer and dropping responses to stale requests.
module fetch_unit #(
    parameter int                    ADDR_WIDTH   = 64,
    parameter int                    INSTR_WIDTH  = 32,
    parameter int                    FIFO_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic    clk,
    input  logic    reset_n,
    fetch_if.master bus
);
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W+1:0] DEPTH_W = (CNT_W+2)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]       out_q, out_d;
    logic [CNT_W-1:0]       drop_q, drop_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       rd_q, rd_d;
    logic [PTR_W-1:0]       wr_q, wr_d;
    logic [INSTR_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  tag_q  [FIFO_DEPTH];

    logic                         req_valid;
    logic                         head_valid;
    logic                         accept;
    logic                         rsp_live;
    logic                         rsp_drop;
    logic                         pop;
    logic [CNT_W+1:0]             in_use;
    logic [PTR_W-1:0]             tag_idx;
    logic signed [ADDR_WIDTH-1:0] target;

    // Credit check, handshake qualifiers and branch target arithmetic
    always_comb begin
        in_use     = (CNT_W+2)'(out_q) + (CNT_W+2)'(count_q) + (CNT_W+2)'(drop_q);
        // Every live request owns a future buffer slot, so a response never
        // needs backpressure; stale requests still hold credit until dropped.
        req_valid  = reset_n && (in_use < DEPTH_W) && !bus.redirect_valid;
        head_valid = (count_q != '0);
        accept     = req_valid && bus.imem_req_ready;
        rsp_live   = bus.imem_rsp_valid && (drop_q == '0);
        rsp_drop   = bus.imem_rsp_valid && (drop_q != '0);
        pop        = head_valid && bus.instr_ready;
        // Live requests occupy the slots just past the buffered entries; the
        // new one goes right after them, so its PC tag is parked there now.
        tag_idx    = wr_q + out_q[PTR_W-1:0];
        target     = $signed(bus.redirect_base) + ($signed(bus.redirect_offset) <<< 2);
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc_q;
    assign bus.instr_valid    = head_valid;
    assign bus.instr          = head_valid ? data_q[rd_q] : '0;
    assign bus.instr_pc       = head_valid ? tag_q[rd_q] : '0;
    assign bus.outstanding    = out_q;

    // Next-state for PC, buffer pointers and request counters
    always_comb begin
        pc_d    = pc_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        out_d   = out_q;
        drop_d  = drop_q;
        if (bus.redirect_valid) begin
            pc_d    = {target[ADDR_WIDTH-1:2], 2'b00};
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            out_d   = '0;
            // Everything still in flight becomes stale, including responses
            // already owed to an earlier redirect; a response consumed this
            // cycle is no longer in flight.
            drop_d  = drop_q - CNT_W'(rsp_drop) + out_q - CNT_W'(rsp_live);
        end else begin
            if (accept) begin
                pc_d = pc_q + ADDR_WIDTH'(4);
            end
            rd_d    = rd_q + PTR_W'(pop);
            wr_d    = wr_q + PTR_W'(rsp_live);
            count_d = count_q + CNT_W'(rsp_live) - CNT_W'(pop);
            out_d   = out_q + CNT_W'(accept) - CNT_W'(rsp_live);
            drop_d  = drop_q - CNT_W'(rsp_drop);
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_VECTOR;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    // Buffer storage: instruction words on live responses, PC tags on accept
    always_ff @(posedge clk) begin
        if (rsp_live && !bus.redirect_valid) begin
            data_q[wr_q] <= bus.imem_rsp_data;
        end
        if (accept) begin
            tag_q[tag_idx] <= pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: fetch_unit bench with a variable-latency memory, a queue-based
// reference model of the decode stream, directed sequences and a redirect table.
module tb_fetch_unit;
    localparam int          AW    = 64;
    localparam int          IW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RV    = 64'h100;
    localparam logic [63:0] RV_W  = 64'hFFFF_FFFF_FFFF_FFF8;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH)) bus ();
    fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH)) wbus ();

    fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH), .RESET_VECTOR(RV))
        dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH), .RESET_VECTOR(RV_W))
        dut_w (.clk(clk), .reset_n(reset_n), .bus(wbus));

    typedef struct {
        logic [63:0] exp_pc;
        logic [63:0] mem_addr;
        int          due;
        bit          live;
    } mreq_t;

    typedef struct {
        logic [63:0] base;
        logic [63:0] off;
        logic [63:0] exp_pc;
    } redir_vec_t;

    int checks   = 0;
    int failures = 0;

    mreq_t       memq[$];
    logic [63:0] bufq[$];
    logic [63:0] m_pc;
    int          edge_cnt;
    int          lat_min;
    int          lat_max;

    bit          drv_req_ready;
    bit          drv_instr_ready;
    bit          drv_redirect;
    logic [63:0] drv_base;
    logic [63:0] drv_off;

    logic        obs_req_valid;
    logic [63:0] obs_addr;
    logic        obs_instr_valid;
    logic [63:0] obs_outstanding;
    logic        obs_pop;
    logic [63:0] obs_pop_pc;
    logic        obs_acc;
    logic        obs_w_valid;
    logic [63:0] obs_w_addr;

    redir_vec_t  tbl [6];
    logic [63:0] wrap_exp [4];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[33:2] ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model, clock, update the model.
    task automatic cycle();
        bit    rsp;
        bit    exp_rv;
        bit    popx;
        int    live;
        mreq_t h;
        rsp = (memq.size() > 0) && (memq[0].due <= edge_cnt + 1);
        bus.imem_req_ready  = drv_req_ready;
        bus.instr_ready     = drv_instr_ready;
        bus.redirect_valid  = drv_redirect;
        bus.redirect_base   = drv_base;
        bus.redirect_offset = drv_off;
        bus.imem_rsp_valid  = rsp;
        bus.imem_rsp_data   = rsp ? mem_word(memq[0].mem_addr) : $urandom();
        #1;
        live = 0;
        foreach (memq[i]) if (memq[i].live) live++;
        exp_rv          = !drv_redirect && ((memq.size() + bufq.size()) < DEPTH);
        obs_req_valid   = bus.imem_req_valid;
        obs_addr        = bus.imem_addr;
        obs_instr_valid = bus.instr_valid;
        obs_outstanding = 64'(bus.outstanding);
        obs_pop         = bus.instr_valid && drv_instr_ready;
        obs_pop_pc      = bus.instr_pc;
        obs_acc         = bus.imem_req_valid && drv_req_ready;
        obs_w_valid     = wbus.imem_req_valid;
        obs_w_addr      = wbus.imem_addr;
        chk("req_valid", 64'(obs_req_valid), 64'(exp_rv));
        if (exp_rv) chk("imem_addr", obs_addr, m_pc);
        chk("instr_valid", 64'(obs_instr_valid), 64'(bufq.size() > 0));
        if (bufq.size() > 0) begin
            chk("instr_pc", bus.instr_pc, bufq[0]);
            chk("instr", 64'(bus.instr), 64'(mem_word(bufq[0])));
        end
        chk("outstanding", obs_outstanding, 64'(live));
        popx = (bufq.size() > 0) && drv_instr_ready;
        @(posedge clk);
        edge_cnt++;
        if (popx && !drv_redirect) void'(bufq.pop_front());
        if (rsp) begin
            h = memq.pop_front();
            if (h.live && !drv_redirect) bufq.push_back(h.exp_pc);
        end
        if (drv_redirect) begin
            bufq.delete();
            foreach (memq[i]) memq[i].live = 1'b0;
            m_pc = (drv_base + drv_off * 64'd4) & ~64'h3;
        end
        if (obs_acc) begin
            memq.push_back('{exp_pc: m_pc, mem_addr: obs_addr,
                             due: edge_cnt + int'($urandom_range(lat_min, lat_max)), live: 1'b1});
            m_pc = m_pc + 64'd4;
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n             = 1'b0;
        drv_redirect        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.imem_rsp_valid  = 1'b0;
        memq.delete();
        bufq.delete();
        m_pc = RV;
        #1;
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_imem_addr", bus.imem_addr, RV);
        chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
        chk("rst_instr", 64'(bus.instr), 64'd0);
        chk("rst_instr_pc", bus.instr_pc, 64'd0);
        chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
        chk("rst_wrap_addr", wbus.imem_addr, RV_W);
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        edge_cnt = 0;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        drv_req_ready   = 1'b0;
        drv_instr_ready = 1'b1;
        drv_redirect    = 1'b0;
        while ((memq.size() > 0 || bus.instr_valid) && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("drain_instr_valid", 64'(bus.instr_valid), 64'd0);
        chk("drain_outstanding", 64'(bus.outstanding), 64'd0);
    endtask

    initial begin
        int n_acc;
        int o;
        bit seen;

        tbl[0] = '{64'h200, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1F8};
        tbl[1] = '{64'h1000, 64'h3, 64'h100C};
        tbl[2] = '{64'h203, 64'h1, 64'h204};
        tbl[3] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h1, 64'h0};
        tbl[5] = '{64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000};
        wrap_exp[0] = 64'hFFFF_FFFF_FFFF_FFF8;
        wrap_exp[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        wrap_exp[2] = 64'h0;
        wrap_exp[3] = 64'h4;

        drv_req_ready = 1'b1; drv_instr_ready = 1'b1; drv_redirect = 1'b0;
        drv_base = '0; drv_off = '0; lat_min = 1; lat_max = 1; edge_cnt = 0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
        bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0;
        bus.redirect_base = '0; bus.redirect_offset = '0;
        wbus.imem_req_ready = 1'b1; wbus.imem_rsp_valid = 1'b0; wbus.imem_rsp_data = '0;
        wbus.instr_ready = 1'b0; wbus.redirect_valid = 1'b0;
        wbus.redirect_base = '0; wbus.redirect_offset = '0;
        #1;

        // Linear fetch from 0x100 with 1-cycle memory; wrap instance runs alongside
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            cycle();
            chk("lin_instr_valid", 64'(obs_instr_valid), 64'(c >= 3));
            if (c <= 3) chk("lin_addr", obs_addr, RV + 64'(4 * (c - 1)));
            if (c <= 4) begin
                chk("wrap_addr", obs_w_addr, wrap_exp[c-1]);
                chk("wrap_req_valid", 64'(obs_w_valid), 64'd1);
            end
            if (c == 5) chk("wrap_credit_stop", 64'(obs_w_valid), 64'd0);
        end
        drain(40);

        // Decode backpressure: exactly FIFO_DEPTH requests, then release
        drv_req_ready = 1'b1; drv_instr_ready = 1'b0; lat_min = 1; lat_max = 1;
        do_reset();
        n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (obs_acc) n_acc++;
        end
        chk("bp_accepts", 64'(n_acc), 64'd4);
        chk("bp_req_valid_low", 64'(obs_req_valid), 64'd0);
        drv_instr_ready = 1'b1;
        drv_req_ready   = 1'b1;
        repeat (8) cycle();
        drain(40);

        // Redirect with three requests in flight
        drv_req_ready = 1'b1; drv_instr_ready = 1'b1; lat_min = 5; lat_max = 5;
        do_reset();
        repeat (3) cycle();
        drv_redirect = 1'b1; drv_base = 64'h200; drv_off = 64'hFFFF_FFFF_FFFF_FFFE;
        cycle();
        chk("rd3_outstanding", obs_outstanding, 64'd3);
        drv_redirect = 1'b0;
        cycle();
        chk("rd3_addr", obs_addr, 64'h1F8);
        chk("rd3_req_valid", 64'(obs_req_valid), 64'd1);
        chk("rd3_instr_valid", 64'(obs_instr_valid), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            cycle();
            if (obs_pop) begin
                seen = 1'b1;
                chk("rd3_first_pc", obs_pop_pc, 64'h1F8);
            end
        end
        chk("rd3_pop_seen", 64'(seen), 64'd1);
        drain(40);

        // Redirect coinciding with a response and a pop
        drv_req_ready = 1'b1; drv_instr_ready = 1'b1; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (5) cycle();
        drv_redirect = 1'b1; drv_base = 64'h4000; drv_off = 64'h4;
        cycle();
        chk("sim_head_valid", 64'(obs_instr_valid), 64'd1);
        chk("sim_pop", 64'(obs_pop), 64'd1);
        drv_redirect = 1'b0;
        cycle();
        chk("sim_fifo_empty", 64'(obs_instr_valid), 64'd0);
        chk("sim_outstanding", obs_outstanding, 64'd0);
        chk("sim_addr", obs_addr, 64'h4010);
        drain(40);

        // Memory stalled for five cycles
        drv_req_ready = 1'b1; drv_instr_ready = 1'b1; lat_min = 2; lat_max = 2;
        do_reset();
        repeat (3) cycle();
        drv_req_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("stall_addr", obs_addr, 64'h10C);
            chk("stall_req_valid", 64'(obs_req_valid), 64'd1);
        end
        drv_req_ready = 1'b1;
        cycle();
        chk("resume_addr0", obs_addr, 64'h10C);
        cycle();
        chk("resume_addr1", obs_addr, 64'h110);
        drain(40);

        // Redirect target table
        lat_min = 1; lat_max = 3;
        drv_req_ready = 1'b1; drv_instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drv_req_ready = 1'b1;
            repeat (3) cycle();
            drain(30);
            drv_req_ready = 1'b1;
            drv_redirect  = 1'b1;
            drv_base      = tbl[i].base;
            drv_off       = tbl[i].off;
            cycle();
            drv_redirect = 1'b0;
            cycle();
            chk("tbl_target", obs_addr, tbl[i].exp_pc);
            chk("tbl_req_valid", 64'(obs_req_valid), 64'd1);
            chk("tbl_instr_valid", 64'(obs_instr_valid), 64'd0);
        end
        drain(40);

        // Randomized traffic with occasional redirects
        lat_min = 1; lat_max = 4;
        drv_req_ready = 1'b1; drv_instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            drv_req_ready   = ($urandom_range(0, 9) < 7);
            drv_instr_ready = ($urandom_range(0, 9) < 6);
            if (!drv_redirect && $urandom_range(0, 24) == 0) begin
                drv_redirect = 1'b1;
                drv_base     = {$urandom(), $urandom()};
                o            = int'($urandom_range(0, 255)) - 128;
                drv_off      = 64'(o);
            end else begin
                drv_redirect = 1'b0;
            end
            cycle();
        end
        drain(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end
endmodule
